uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte channel among N_REQ requesters, e.g. core debug console, boot loader and trace unit.
- Round-robin arbitration with frame lock: a multi-byte frame marked by req_last_i is never interleaved with another source's bytes.
- One-entry registered output stage feeds the UART TX serializer through a valid/ready handshake.
- Stuck frames are released by a lock-timeout counter.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_W, 8, byte width per beat.
- LOCK_TO, 1024, idle cycles allowed inside a locked frame before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester beat valid.
- req_data_i  in  N_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last_i  in  N_REQ  beat is the final byte of its frame.
- req_ready_o  out  N_REQ  beat accepted this cycle, valid & ready.
- tx_valid_o  out  1  output byte valid (registered).
- tx_data_o  out  DATA_W  output byte (registered).
- tx_src_o  out  $clog2(N_REQ)  index of the source of tx_data_o (registered).
- tx_ready_i  in  1  serializer accepts byte.
- busy_o  out  1  FSM in LOCKED or tx_valid_o high.
- err_timeout_o  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset (async assert, sync deassert externally):
  - tx_valid_o=0, tx_data_o=0, tx_src_o=0, err_timeout_o=0.
  - FSM=IDLE, rr_ptr=N_REQ-1 so requester 0 has first priority, timeout counter=0.
  - Reset mid-frame discards the partial frame and any held output byte.
- Output stage: out_free = !tx_valid_o | tx_ready_i.
  - On accept, tx_data_o/tx_src_o load and tx_valid_o=1 next cycle.
  - If tx_ready_i with no accept, tx_valid_o=0.
  - Held data stays stable while tx_valid_o & !tx_ready_i.
- Latency: requester accept to tx_valid_o is 1 cycle. Full throughput: 1 byte/cycle when tx_ready_i is held high.
- req_ready_o is combinational from req_valid_i, FSM state, rr_ptr and tx state. At most one bit is high. It is never high when !out_free.
- IDLE state:
  - Winner = first i with req_valid_i[i], scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - req_ready_o[winner]=out_free.
  - Accept with last=1: stay IDLE, rr_ptr<=winner.
  - Accept with last=0: go to LOCKED, lock_src<=winner, rr_ptr<=winner.
- LOCKED state:
  - Only lock_src is eligible; req_ready_o[lock_src]=out_free.
  - Accept with last=1 returns to IDLE.
  - Other requesters wait regardless of their valid.
- Timeout (LOCK_TO>0):
  - Counter runs in LOCKED while !req_valid_i[lock_src]. It clears on any valid from lock_src and on leaving LOCKED.
  - When the counter reaches LOCK_TO-1 and valid is still low: go to IDLE, pulse err_timeout_o for 1 cycle, clear the counter.
  - A valid beat in that same cycle wins; no timeout fires.
  - Output backpressure (!out_free while valid high) never counts toward the timeout.
- Requester rules: once valid is high, data/last must be held until ready. Dropping valid in IDLE is tolerated; arbitration simply re-evaluates.
- Simultaneous events: tx_ready_i and a new accept in the same cycle replace the output byte with no bubble.
- rr_ptr wraps N_REQ-1 -> 0.
- busy_o = (FSM==LOCKED) | tx_valid_o.

Test Plan:
- Single-byte streams: reqs 0,1,2 all valid with last=1, data 0x10/0x20/0x30, tx_ready_i=1 -> tx_data_o sequence 0x10,0x20,0x30,0x10…; tx_src_o 0,1,2,0,…; one byte per cycle.
- Frame lock: req1 sends 3-byte frame 0xA1,0xA2,0xA3 (last on third) while req0/req2 stay valid -> three consecutive outputs from src 1, then src 2, then src 0.
- Backpressure: tx_ready_i=0 for 5 cycles with req0 valid 0x55 -> tx_valid_o=1 with 0x55 held stable, req_ready_o=0 for all; tx_ready_i=1 -> next byte follows in the same cycle.
- Timeout with LOCK_TO=8: req3 sends 0x01 (last=0) then drops valid -> err_timeout_o pulses 8 cycles after the valid drop; FSM returns to IDLE; pending req0 byte granted next.
- Reset mid-frame: assert rst_n=0 while LOCKED on src 2 with tx_valid_o=1 -> tx_valid_o=0 immediately; after release, req0 receives the first grant.
- Wrap/priority: rr_ptr=N_REQ-1 after reset, all four requesters valid -> grant order 0,1,2,3,0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and UART-TX handshake bundle for uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int c_SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_last_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    tx_valid_o;
  logic [DATA_W-1:0]       tx_data_o;
  logic [c_SRC_W-1:0]      tx_src_o;
  logic                    tx_ready_i;
  logic                    busy_o;
  logic                    err_timeout_o;

  // Requester/serializer side.
  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o, tx_src_o, busy_o, err_timeout_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o, tx_src_o, busy_o, err_timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, frame-locking arbiter sharing one UART TX byte channel.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int LOCK_TO = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int c_SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_POS_W = c_SRC_W + 1;
  localparam logic [c_POS_W-1:0] c_N_REQ   = c_POS_W'(N_REQ);
  localparam logic [c_SRC_W-1:0] c_RR_INIT = c_SRC_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_SRC_W-1:0]  r_rr_ptr;
  logic [c_SRC_W-1:0]  w_rr_ptr_nxt;
  logic [c_SRC_W-1:0]  r_lock_src;
  logic [c_SRC_W-1:0]  w_lock_src_nxt;

  logic                r_tx_valid;
  logic [DATA_W-1:0]   r_tx_data;
  logic [c_SRC_W-1:0]  r_tx_src;
  logic                r_err_timeout;

  logic                w_scan_vld;
  logic [c_SRC_W-1:0]  w_scan_idx;
  logic [c_POS_W-1:0]  w_scan_pos;
  logic                w_grant_vld;
  logic [c_SRC_W-1:0]  w_grant_idx;
  logic [DATA_W-1:0]   w_grant_data;
  logic                w_grant_last;
  logic                w_out_free;
  logic                w_accept;
  logic                w_to_fire;
  logic [N_REQ-1:0]    w_req_ready;

  // Rotating scan from rr_ptr+1; the descending loop leaves the nearest
  // valid requester as the final assignment.
  always_comb begin
    w_scan_vld = 1'b0;
    w_scan_idx = '0;
    w_scan_pos = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_scan_pos = {1'b0, r_rr_ptr} + c_POS_W'(k);
      if (w_scan_pos >= c_N_REQ) begin
        w_scan_pos = w_scan_pos - c_N_REQ;
      end
      if (bus.req_valid_i[w_scan_pos[c_SRC_W-1:0]]) begin
        w_scan_vld = 1'b1;
        w_scan_idx = w_scan_pos[c_SRC_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_lock_src;
    if (r_state == ST_LOCKED) begin
      w_grant_vld = bus.req_valid_i[r_lock_src];
    end else begin
      w_grant_vld = w_scan_vld;
      w_grant_idx = w_scan_idx;
    end
  end

  assign w_out_free   = ~r_tx_valid | bus.tx_ready_i;
  assign w_accept     = w_grant_vld & w_out_free;
  assign w_grant_data = bus.req_data_i[w_grant_idx*DATA_W +: DATA_W];
  assign w_grant_last = bus.req_last_i[w_grant_idx];

  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Lock watchdog: counts only cycles where the owner presents nothing, so
  // output backpressure never contributes.
  generate
    if (LOCK_TO > 0) begin : g_timeout
      localparam int c_CNT_W = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
      localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(LOCK_TO - 1);

      logic [c_CNT_W-1:0] r_to_cnt;
      logic [c_CNT_W-1:0] w_to_cnt_nxt;
      logic               w_fire;

      always_comb begin
        w_fire       = 1'b0;
        w_to_cnt_nxt = '0;
        if ((r_state == ST_LOCKED) && !bus.req_valid_i[r_lock_src]) begin
          if (r_to_cnt == c_TO_LAST) begin
            w_fire = 1'b1;
          end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= w_to_cnt_nxt;
        end
      end

      assign w_to_fire = w_fire;
    end else begin : g_no_timeout
      assign w_to_fire = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_lock_src_nxt = r_lock_src;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_rr_ptr_nxt = w_grant_idx;
          if (!w_grant_last) begin
            w_state_nxt    = ST_LOCKED;
            w_lock_src_nxt = w_grant_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          if (w_grant_last) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_to_fire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= c_RR_INIT;
      r_lock_src <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_lock_src <= w_lock_src_nxt;
    end
  end

  // Single-entry output register; a same-cycle drain and accept overwrite
  // the entry so the serializer sees no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_tx_src      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_to_fire;
      if (w_accept) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_grant_data;
        r_tx_src   <= w_grant_idx;
      end else if (bus.tx_ready_i) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o   = w_req_ready;
  assign bus.tx_valid_o    = r_tx_valid;
  assign bus.tx_data_o     = r_tx_data;
  assign bus.tx_src_o      = r_tx_src;
  assign bus.busy_o        = (r_state == ST_LOCKED) | r_tx_valid;
  assign bus.err_timeout_o = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed and random stimulus against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int LOCK_TO = 8;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    int         src;
    int         cyc;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus();

  uart_tx_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .LOCK_TO(LOCK_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t src_q[N_REQ][$];
  int    gap_left[N_REQ];
  logic  tx_rdy_drv = 1'b1;
  bit    rnd_mode   = 1'b0;
  xfer_t xlog[$];
  int    ed[$];
  int    es[$];
  int    cyc     = 0;
  int    err_cyc = -1;
  int    n_err   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_log(input string name);
    chk({name, "_count"}, xlog.size(), ed.size());
    for (int j = 0; j < ed.size() && j < xlog.size(); j++) begin
      chk({name, "_data"}, {24'd0, xlog[j].data}, ed[j]);
      chk({name, "_src"}, xlog[j].src, es[j]);
    end
  endfunction

  // Reference model: owner of the open frame (-1 = none), last winner, and
  // the byte the serializer should currently be offered.
  int         m_owner = -1;
  int         m_rr    = N_REQ - 1;
  int         m_idle  = 0;
  logic       m_tv    = 1'b0;
  logic [7:0] m_td    = 8'h00;
  int         m_ts    = 0;
  logic       m_err   = 1'b0;

  always @(negedge clk) begin
    int               win;
    int               prev_owner;
    int               idx;
    logic             ofree;
    logic [N_REQ-1:0] exp_rdy;
    xfer_t            x;
    cyc++;
    if (!rst_n) begin
      m_owner = -1; m_rr = N_REQ - 1; m_idle = 0;
      m_tv = 1'b0; m_td = 8'h00; m_ts = 0; m_err = 1'b0;
      chk("rst_tx_valid", {31'd0, bus.tx_valid_o}, 0);
      chk("rst_tx_data", {24'd0, bus.tx_data_o}, 0);
      chk("rst_tx_src", {30'd0, bus.tx_src_o}, 0);
      chk("rst_err", {31'd0, bus.err_timeout_o}, 0);
      chk("rst_busy", {31'd0, bus.busy_o}, 0);
    end else begin
      win = -1;
      if (m_owner < 0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          idx = (m_rr + k) % N_REQ;
          if (win < 0 && bus.req_valid_i[idx]) win = idx;
        end
      end else if (bus.req_valid_i[m_owner]) begin
        win = m_owner;
      end
      ofree   = !m_tv || bus.tx_ready_i;
      exp_rdy = '0;
      if (win >= 0 && ofree) exp_rdy[win] = 1'b1;

      chk("req_ready", {28'd0, bus.req_ready_o}, {28'd0, exp_rdy});
      chk("tx_valid", {31'd0, bus.tx_valid_o}, {31'd0, m_tv});
      if (m_tv) begin
        chk("tx_data", {24'd0, bus.tx_data_o}, {24'd0, m_td});
        chk("tx_src", {30'd0, bus.tx_src_o}, m_ts);
      end
      chk("busy", {31'd0, bus.busy_o}, {31'd0, (m_owner >= 0) || m_tv});
      chk("err_timeout", {31'd0, bus.err_timeout_o}, {31'd0, m_err});

      if (bus.tx_valid_o && bus.tx_ready_i) begin
        x.data = bus.tx_data_o; x.src = int'(bus.tx_src_o); x.cyc = cyc;
        xlog.push_back(x);
      end
      if (bus.err_timeout_o) begin
        err_cyc = cyc;
        n_err++;
      end

      prev_owner = m_owner;
      m_err      = 1'b0;
      if (win >= 0 && ofree) begin
        m_tv = 1'b1;
        m_td = bus.req_data_i[win*DATA_W +: DATA_W];
        m_ts = win;
        if (m_owner < 0) m_rr = win;
        m_owner = bus.req_last_i[win] ? -1 : win;
      end else if (bus.tx_ready_i) begin
        m_tv = 1'b0;
      end
      if (prev_owner >= 0) begin
        if (bus.req_valid_i[prev_owner]) m_idle = 0;
        else if (m_idle == LOCK_TO - 1) begin
          m_owner = -1; m_err = 1'b1; m_idle = 0;
        end else m_idle++;
      end else begin
        m_idle = 0;
      end
    end
  end

  function automatic void push_beat(input int i, input logic [7:0] d, input logic l, input int g);
    beat_t b;
    b.data = d; b.last = l; b.gap = g;
    if (src_q[i].size() == 0) gap_left[i] = g;
    src_q[i].push_back(b);
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N_REQ; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  function automatic void drive();
    logic [N_REQ-1:0]        v;
    logic [N_REQ-1:0]        l;
    logic [N_REQ*DATA_W-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() > 0 && gap_left[i] == 0) begin
        v[i] = 1'b1;
        l[i] = src_q[i][0].last;
        d[i*DATA_W +: DATA_W] = src_q[i][0].data;
      end
    end
    bus.req_valid_i = v;
    bus.req_last_i  = l;
    bus.req_data_i  = d;
    bus.tx_ready_i  = tx_rdy_drv;
  endfunction

  function automatic void clear_queues();
    for (int i = 0; i < N_REQ; i++) begin
      src_q[i].delete();
      gap_left[i] = 0;
    end
  endfunction

  // One clock: note which beats the DUT takes, retire them, refresh inputs.
  task automatic cycle();
    logic [N_REQ-1:0] rdy;
    logic             rs;
    int               len;
    @(negedge clk);
    rdy = bus.req_ready_o;
    rs  = rst_n;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (rs && rdy[i] && src_q[i].size() > 0) begin
        src_q[i].delete(0);
        if (src_q[i].size() > 0) gap_left[i] = src_q[i][0].gap;
      end else if (src_q[i].size() > 0 && gap_left[i] > 0) begin
        gap_left[i]--;
      end
    end
    if (rnd_mode) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(3) == 0) begin
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++)
            push_beat(i, 8'($urandom), b == len - 1,
                      ($urandom_range(9) == 0) ? int'($urandom_range(12, 1)) : 0);
        end
      end
      tx_rdy_drv = ($urandom_range(3) != 0);
    end
    drive();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((pending() || bus.busy_o) && n < 300) begin
      cycle();
      n++;
    end
    chk({name, "_drain"}, {31'd0, n < 300}, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_queues();
    rst_n = 1'b1;
    drive();
    #1 rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {28'd0, bus.req_ready_o}, 0);
    chk("post_rst_valid", {31'd0, bus.tx_valid_o}, 0);

    // Single-byte streams from 0,1,2: strict rotation at one byte per cycle.
    xlog.delete();
    for (int j = 0; j < 3; j++)
      for (int r = 0; r < 3; r++) push_beat(r, 8'(16 * (r + 1)), 1'b1, 0);
    drive();
    drain("s1");
    ed = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
    es = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    chk_log("s1");
    for (int j = 1; j < xlog.size(); j++) chk("s1_rate", xlog[j].cyc - xlog[j-1].cyc, 1);

    // Frame lock: req0 alone first, then req1's 3-byte frame holds off 2 and 0.
    xlog.delete();
    push_beat(0, 8'h0A, 1'b1, 0);
    drive();
    drain("s2a");
    push_beat(1, 8'hA1, 1'b0, 0);
    push_beat(1, 8'hA2, 1'b0, 0);
    push_beat(1, 8'hA3, 1'b1, 0);
    push_beat(0, 8'h0B, 1'b1, 0);
    push_beat(2, 8'h2C, 1'b1, 0);
    drive();
    drain("s2b");
    ed = '{8'h0A, 8'hA1, 8'hA2, 8'hA3, 8'h2C, 8'h0B};
    es = '{0, 1, 1, 1, 2, 0};
    chk_log("s2");

    // Backpressure: 0x55 held for 5 cycles, then 0x56 follows without a gap.
    xlog.delete();
    tx_rdy_drv = 1'b0;
    push_beat(0, 8'h55, 1'b1, 0);
    push_beat(0, 8'h56, 1'b1, 0);
    drive();
    for (int j = 0; j < 6; j++) begin
      cycle();
      #1;
      chk("s3_hold_valid", {31'd0, bus.tx_valid_o}, 1);
      chk("s3_hold_data", {24'd0, bus.tx_data_o}, 32'h55);
      chk("s3_hold_ready", {28'd0, bus.req_ready_o}, 0);
    end
    tx_rdy_drv = 1'b1;
    drive();
    drain("s3");
    ed = '{8'h55, 8'h56};
    es = '{0, 0};
    chk_log("s3");
    if (xlog.size() >= 2) chk("s3_no_bubble", xlog[1].cyc - xlog[0].cyc, 1);

    // Lock timeout: req3 opens a frame and goes silent; req0 waits.
    xlog.delete();
    n_err = 0;
    push_beat(3, 8'h01, 1'b0, 0);
    push_beat(0, 8'h77, 1'b1, 0);
    drive();
    drain("s4");
    ed = '{8'h01, 8'h77};
    es = '{3, 0};
    chk_log("s4");
    chk("s4_err_count", n_err, 1);
    if (xlog.size() >= 2) begin
      chk("s4_err_delay", err_cyc - xlog[0].cyc, 8);
      chk("s4_grant_after", xlog[1].cyc - err_cyc, 1);
    end

    // Reset while locked on req2 with a held output byte.
    tx_rdy_drv = 1'b0;
    push_beat(2, 8'hC1, 1'b0, 0);
    push_beat(2, 8'hC2, 1'b0, 0);
    push_beat(2, 8'hC3, 1'b1, 0);
    drive();
    cycle();
    cycle();
    #1;
    chk("s5_pre_busy", {31'd0, bus.busy_o}, 1);
    chk("s5_pre_valid", {31'd0, bus.tx_valid_o}, 1);
    rst_n = 1'b0;
    #1;
    chk("s5_async_valid", {31'd0, bus.tx_valid_o}, 0);
    chk("s5_async_busy", {31'd0, bus.busy_o}, 0);
    clear_queues();
    drive();
    repeat (2) cycle();
    rst_n = 1'b1;
    tx_rdy_drv = 1'b1;
    xlog.delete();
    for (int j = 0; j < 2; j++)
      for (int r = 0; r < N_REQ; r++) push_beat(r, 8'(8'hE0 + 16 * j + r), 1'b1, 0);
    drive();
    drain("s5");
    ed = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
    es = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("s5");

    // Random frames, gaps and backpressure, with one reset mid-run.
    rnd_mode = 1'b1;
    repeat (1500) cycle();
    rnd_mode = 1'b0;
    rst_n = 1'b0;
    clear_queues();
    drive();
    repeat (2) cycle();
    rst_n = 1'b1;
    rnd_mode = 1'b1;
    repeat (1500) cycle();
    rnd_mode = 1'b0;
    tx_rdy_drv = 1'b1;
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
